// File: rtl/ne16_pres_accumulator_if.sv
// Stream bundle between the binconv array, the pres accumulator and the
// normalization stage: one shared-handshake pres input stream and one
// drained accumulator output stream. The accumulator is the slave side.
interface ne16_pres_accumulator_if #(
  parameter int unsigned NR_COLUMN  = 9,
  parameter int unsigned PRES_WIDTH = 28,
  parameter int unsigned ACC_WIDTH  = 32
) ();

  logic [NR_COLUMN*PRES_WIDTH-1:0] pres_data;
  logic                            pres_valid;
  logic                            pres_ready;
  logic [NR_COLUMN*ACC_WIDTH-1:0]  acc_data;
  logic                            acc_valid;
  logic                            acc_last;
  logic                            acc_ready;

  modport master (
    output pres_data, pres_valid, acc_ready,
    input  pres_ready, acc_data, acc_valid, acc_last
  );

  modport slave (
    input  pres_data, pres_valid, acc_ready,
    output pres_ready, acc_data, acc_valid, acc_last
  );

endinterface

// File: rtl/ne16_pres_accumulator.sv
// Partial-result accumulator behind the binconv array. Accumulates the
// per-column pres stream over npass input-channel passes into a flop bank
// (one entry per output pixel per lane), then drains the bank as a stream.
// Optional macro NE16_ACC_SATURATE_EN: accumulation clips to the signed
// ACC_WIDTH range instead of wrapping.
module ne16_pres_accumulator #(
  parameter int unsigned NR_COLUMN  = 9,
  parameter int unsigned PRES_WIDTH = 28,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  input  logic [7:0]               npass_i,
  ne16_pres_accumulator_if.slave   bus,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  typedef logic [NR_COLUMN-1:0][ACC_WIDTH-1:0] entry_t;

  state_t              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [7:0]          npass_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   daddr_q;
  logic [7:0]          pass_q;
  logic                done_q;

  entry_t              acc_q [DEPTH];
  entry_t              acc_next;

  logic                pres_hs;
  logic                acc_hs;
  logic                addr_last;
  logic                daddr_last;
  logic                pass_last;

  assign pres_hs    = (state_q == ACCUM) && bus.pres_valid;
  assign acc_hs     = (state_q == DRAIN) && bus.acc_ready;
  // len_q >= 1 whenever these are used, so len-1 always fits the address width.
  assign addr_last  = (addr_q  == ADDR_W'(len_q - LEN_W'(1)));
  assign daddr_last = (daddr_q == ADDR_W'(len_q - LEN_W'(1)));
  assign pass_last  = (pass_q  == npass_q - 8'd1);

  // One lane of the entry update: load on pass 0, accumulate afterwards.
  function automatic logic [ACC_WIDTH-1:0] lane_update(
    input logic [ACC_WIDTH-1:0]  cur,
    input logic [PRES_WIDTH-1:0] pres,
    input logic                  first
  );
    logic signed [ACC_WIDTH-1:0] ext;
`ifdef NE16_ACC_SATURATE_EN
    logic signed [ACC_WIDTH:0]   wide;
`endif
    ext = ACC_WIDTH'(signed'(pres));
    if (first) return ext;
`ifdef NE16_ACC_SATURATE_EN
    wide = (ACC_WIDTH+1)'(signed'(cur)) + (ACC_WIDTH+1)'(ext);
    // Overflow shows up as disagreement between the guard bit and the MSB.
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
      return wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return wide[ACC_WIDTH-1:0];
`else
    return cur + ext;
`endif
  endfunction

  // Next value of the entry addressed by the current pres beat, all lanes.
  always_comb begin
    // NOTE: default first so no path leaves acc_next unassigned (no latch).
    acc_next = '0;
    for (int c = 0; c < NR_COLUMN; c++)
      acc_next[c] = lane_update(acc_q[addr_q][c],
                                bus.pres_data[c*PRES_WIDTH +: PRES_WIDTH],
                                pass_q == 8'd0);
  end

  // Accumulator bank: written on every accepted, non-aborted pres beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the bank is flops, not SRAM, so it is cleared by reset; clear_i leaves it.
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else if (pres_hs && !clear_i) begin
      acc_q[addr_q] <= acc_next;
    end
  end

  // Control FSM: job setup, pass/address sequencing, drain, done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      npass_q <= '0;
      addr_q  <= '0;
      daddr_q <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        state_q <= IDLE;
        addr_q  <= '0;
        daddr_q <= '0;
        pass_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              if (len_i != '0 && npass_i != 8'd0) begin
                len_q   <= len_i;
                npass_q <= npass_i;
                addr_q  <= '0;
                pass_q  <= '0;
                state_q <= ACCUM;
              end else begin
                done_q  <= 1'b1;
              end
            end
          end
          ACCUM: begin
            if (pres_hs) begin
              if (addr_last) begin
                addr_q <= '0;
                if (pass_last) begin
                  pass_q  <= '0;
                  daddr_q <= '0;
                  state_q <= DRAIN;
                end else begin
                  pass_q <= pass_q + 8'd1;
                end
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
              end
            end
          end
          DRAIN: begin
            if (acc_hs) begin
              if (daddr_last) begin
                daddr_q <= '0;
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                daddr_q <= daddr_q + ADDR_W'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.pres_ready = (state_q == ACCUM);
  assign bus.acc_valid  = (state_q == DRAIN);
  assign bus.acc_last   = (state_q == DRAIN) && daddr_last;
  assign bus.acc_data   = acc_q[daddr_q];
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;

endmodule

// File: doc/ne16_pres_accumulator.md
Name: ne16_pres_accumulator

Overview:
Downstream stage of the binconv array. Consumes the per-column partial-result (pres) stream, accumulates it over several input-channel passes into a register-based accumulator bank, one entry per output pixel. Once the last pass completes, it drains the bank as a stream toward normalization/quantization. All columns share one valid/ready handshake, matching the array's shared column handshake.

Parameters:
NR_COLUMN, 9, number of pres lanes (one per array column)
PRES_WIDTH, 28, signed width of each incoming pres lane
ACC_WIDTH, 32, signed width of each accumulator entry (must be >= PRES_WIDTH)
DEPTH, 16, number of accumulator entries (output pixels) per lane

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous abort; returns the block to IDLE
start_i  in  1  starts a job; sampled only in IDLE
len_i  in  $clog2(DEPTH)+1  entries per pass (0..DEPTH); sampled at start
npass_i  in  8  number of accumulation passes; sampled at start
pres_data_i  in  NR_COLUMN*PRES_WIDTH  lane c at bits [c*PRES_WIDTH +: PRES_WIDTH], signed
pres_valid_i  in  1  pres beat valid
pres_ready_o  out  1  pres beat accepted
acc_data_o  out  NR_COLUMN*ACC_WIDTH  drained entry, lane-packed like the input
acc_valid_o  out  1  drain beat valid
acc_last_o  out  1  marks the final drain beat
acc_ready_i  in  1  downstream ready
busy_o  out  1  high in ACCUM or DRAIN
done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: all outputs 0. State IDLE; addr, pass and drain counters 0. Accumulator bank set to 0 on reset only; clear_i does not zero it.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start_i with len_i != 0 and npass_i != 0: latch len/npass, go to ACCUM.
  - start_i with len_i == 0 or npass_i == 0: stay in IDLE and pulse done_o on the next cycle; no beats are exchanged.
- ACCUM:
  - pres_ready_o = 1 only in this state (combinational from state).
  - Each handshake (pres_valid_i & pres_ready_o) updates entry acc[addr] in every lane:
    - pass 0: acc = sext(pres)
    - later passes: acc = acc + sext(pres)
  - The update is visible in the register one cycle after the handshake.
  - addr increments per handshake. At addr == len-1 it wraps to 0 and pass increments.
  - Handshake at addr == len-1 and pass == npass-1: go to DRAIN on the next cycle.
- DRAIN:
  - acc_valid_o = 1; acc_data_o = acc[daddr], read combinationally from the flops.
  - acc_last_o = (daddr == len-1).
  - Each acc_valid_o & acc_ready_i handshake increments daddr.
  - The last handshake moves to IDLE and asserts done_o for one cycle on the following cycle.
  - acc_data_o and acc_last_o stay stable while valid and not ready.
- Arithmetic: two's complement; the sum wraps modulo 2^ACC_WIDTH unless the optional feature is compiled in. Lanes are independent.
- start_i outside IDLE is ignored.
- clear_i has priority over every event, including a same-cycle handshake or start:
  - next state IDLE; counters 0; done_o not pulsed.
  - A pres beat presented in the same cycle is handshaken (ready was high) but discarded; no entry update.
- Asynchronous reset mid-job: immediate return to the reset values listed above.
- Entries at addr >= len are never written or read during the job.
- busy_o = (state != IDLE).

Optional Feature:
NE16_ACC_SATURATE_EN
- Defined: each addition clips to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] per lane.
- Not defined: plain wrap-around addition.
- The pass-0 load is unaffected either way.

Test Plan:
1. Basic accumulate, npass=1:
   - Stimulus: len=4, npass=1; pres lane c of beat k = 10*k+c.
   - Response: drains 4 beats with identical values; acc_last_o only on beat 3; done_o pulses once, one cycle after the final handshake.
2. Multi-pass with negative sign extension:
   - Stimulus: len=3, npass=3, every lane = -5 on each beat.
   - Response: each drained entry is -15 (0xFFFFFFF1 at ACC_WIDTH=32).
3. Backpressure on both sides:
   - Stimulus: random gaps in pres_valid_i; acc_ready_i low for 3 cycles mid-drain.
   - Response: no beat lost or duplicated; acc_data_o stable while stalled; results equal those of case 2.
4. Degenerate start:
   - Stimulus: start with len=0, then start with npass=0.
   - Response: pres_ready_o and acc_valid_o stay 0; busy_o stays 0; done_o pulses once, one cycle after each start.
5. Abort:
   - Stimulus: clear_i during pass 1 of a len=4, npass=2 job, then a new job len=2, npass=1 with values 7.
   - Response: immediate IDLE with no done_o; the new job drains 7, 7 (pass 0 overwrites stale data).
6. Overflow:
   - Stimulus: ACC_WIDTH=PRES_WIDTH=8, npass=2, both beats = 100.
   - Response: drained value is -56 without NE16_ACC_SATURATE_EN, 127 with it.
